// File: rtl/bemf_accum.sv
// Back-EMF sampling pipeline: (adc_h - adc_l - calib), asymmetric deadband, per-channel accumulate.
// Optional macro BEMF_ACCUM_SAT_EN: saturate the accumulator instead of wrapping.
module bemf_accum #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int unsigned ADC_W  = 10,
  parameter int unsigned ACC_W  = 20,
  parameter int unsigned DB_POS = 20,
  parameter int unsigned DB_NEG = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADC_W-1:0]  adc_h,
  input  logic [ADC_W-1:0]  adc_l,
  input  logic [CH_W-1:0]   ch_in,
  input  logic              in_valid,
  input  logic              calib_we,
  input  logic [CH_W-1:0]   calib_ch,
  input  logic [ACC_W-1:0]  calib_data,
  input  logic              clr_valid,
  input  logic [CH_W-1:0]   clr_ch,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [ACC_W-1:0]  rd_data,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [ACC_W-1:0]  out_bemf
);

  localparam logic signed [ACC_W-1:0] DB_POS_V = ACC_W'(DB_POS);
  localparam logic signed [ACC_W-1:0] DB_NEG_V = -ACC_W'(DB_NEG);

  logic signed [ACC_W-1:0] acc_q   [NUM_CH];
  logic signed [ACC_W-1:0] calib_q [NUM_CH];

  // Pipeline registers
  logic                    s0_v, s1_v, s2_v, s3_v;
  logic [CH_W-1:0]         s0_ch, s1_ch, s2_ch, s3_ch;
  logic [ADC_W-1:0]        s0_h, s0_l;
  logic signed [ACC_W-1:0] s1_diff, s1_calib;
  logic signed [ACC_W-1:0] s2_delta, s3_delta;

  logic signed [ACC_W-1:0] calib_sel;
  logic signed [ACC_W-1:0] d_c;
  logic signed [ACC_W-1:0] delta_c;
  logic signed [ACC_W-1:0] acc_cur;
  logic signed [ACC_W-1:0] acc_sum;
  logic                    s3_ok;
  logic                    s3_upd;
  logic                    clr_hit;

  // Calibration lookup for the sample entering S1 (pre-edge value, so same-cycle writes are not seen)
  always_comb begin
    calib_sel = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (s0_ch == CH_W'(i)) calib_sel = calib_q[i];
    end
  end

  // Offset removal and asymmetric deadband
  always_comb begin
    d_c     = s1_diff - s1_calib;
    delta_c = d_c;
    if ((d_c >= DB_NEG_V) && (d_c <= DB_POS_V)) delta_c = '0;
  end

  // S3 accumulator read; out-of-range channels fall through without an update
  always_comb begin
    acc_cur = '0;
    s3_ok   = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (s3_ch == CH_W'(i)) begin
        acc_cur = acc_q[i];
        s3_ok   = 1'b1;
      end
    end
  end

`ifdef BEMF_ACCUM_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic signed [ACC_W:0] sum_ext;

  // One guard bit detects overflow; clamp toward the sign of the true sum
  always_comb begin
    sum_ext = {acc_cur[ACC_W-1], acc_cur} + {s3_delta[ACC_W-1], s3_delta};
    acc_sum = sum_ext[ACC_W-1:0];
    if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) acc_sum = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
  end
`else
  always_comb begin
    acc_sum = acc_cur + s3_delta;
  end
`endif

  always_comb begin
    s3_upd  = s3_v && s3_ok;
    clr_hit = clr_valid && (clr_ch == s3_ch);
  end

  // Datapath pipeline S0..S3
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_v     <= 1'b0;
      s1_v     <= 1'b0;
      s2_v     <= 1'b0;
      s3_v     <= 1'b0;
      s0_ch    <= '0;
      s1_ch    <= '0;
      s2_ch    <= '0;
      s3_ch    <= '0;
      s0_h     <= '0;
      s0_l     <= '0;
      s1_diff  <= '0;
      s1_calib <= '0;
      s2_delta <= '0;
      s3_delta <= '0;
    end else begin
      s0_v     <= in_valid;
      s0_ch    <= ch_in;
      s0_h     <= adc_h;
      s0_l     <= adc_l;
      s1_v     <= s0_v;
      s1_ch    <= s0_ch;
      s1_diff  <= ACC_W'(s0_h) - ACC_W'(s0_l);
      s1_calib <= calib_sel;
      s2_v     <= s1_v;
      s2_ch    <= s1_ch;
      s2_delta <= delta_c;
      s3_v     <= s2_v;
      s3_ch    <= s2_ch;
      s3_delta <= s2_delta;
    end
  end

  // Calibration storage; writes to channels beyond NUM_CH match no entry
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) calib_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (calib_we && (calib_ch == CH_W'(i))) calib_q[i] <= calib_data;
      end
    end
  end

  // Accumulator storage; a clear beats a same-channel update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (clr_valid && (clr_ch == CH_W'(i))) acc_q[i] <= '0;
        else if (s3_upd && (s3_ch == CH_W'(i))) acc_q[i] <= acc_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_bemf  <= '0;
    end else begin
      out_valid <= s3_upd;
      if (s3_upd) begin
        out_ch   <= s3_ch;
        out_bemf <= clr_hit ? '0 : acc_sum;
      end
    end
  end

  // Storage read port, no bypass from the in-flight S3 update
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) rd_data = acc_q[i];
    end
  end

endmodule
